// File: rtl/logic_gate_unit.sv
// Bitwise logic unit with a 2-entry in-order result buffer and valid/ready handshakes.
// Optional macro LOGIC_GATE_UNIT_POPCNT_EN adds out_popcnt (count of ones in out_data).
module logic_gate_unit #(
    parameter int          WIDTH  = 8,
    parameter logic [2:0]  DEF_OP = 3'b010,
    localparam int         PCW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       op,
    input  logic             op_sel_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef LOGIC_GATE_UNIT_POPCNT_EN
    output logic [PCW-1:0]   out_popcnt,
`endif
    output logic             out_zero
);

    // state | meaning
    // EMPTY | no buffered result
    // ONE   | entry 0 holds the only result
    // TWO   | entry 0 oldest, entry 1 newest; input stalled
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic             zero0_q, zero0_d, zero1_q, zero1_d;
    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic [2:0]       eff_op;
    logic             accept, consume;

`ifdef LOGIC_GATE_UNIT_POPCNT_EN
    logic [PCW-1:0]   pc0_q, pc0_d, pc1_q, pc1_d;
    logic [PCW-1:0]   res_pc;

    function automatic logic [PCW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + PCW'(v[i]);
        return c;
    endfunction

    assign res_pc     = popcount(res);
    assign out_popcnt = pc0_q;
`endif

    assign eff_op = op_sel_en ? op : DEF_OP;

    always_comb begin
        res = '0;
        case (eff_op)
            3'b000:  res = in_a & in_b;
            3'b001:  res = in_a | in_b;
            3'b010:  res = ~(in_a | in_b);
            3'b011:  res = ~(in_a & in_b);
            3'b100:  res = in_a ^ in_b;
            3'b101:  res = ~(in_a ^ in_b);
            3'b110:  res = ~in_a;
            default: res = in_a;
        endcase
    end

    assign res_zero  = (res == '0);
    assign accept    = in_valid && in_ready_q;
    assign consume   = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = data0_q;
    assign out_zero  = zero0_q;

    // Entry 0 is always the head; a pop from TWO shifts entry 1 down.
    always_comb begin
        state_d = state_q;
        data0_d = data0_q;
        data1_d = data1_q;
        zero0_d = zero0_q;
        zero1_d = zero1_q;
`ifdef LOGIC_GATE_UNIT_POPCNT_EN
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    data0_d = res;
                    zero0_d = res_zero;
`ifdef LOGIC_GATE_UNIT_POPCNT_EN
                    pc0_d   = res_pc;
`endif
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    data0_d = res;
                    zero0_d = res_zero;
`ifdef LOGIC_GATE_UNIT_POPCNT_EN
                    pc0_d   = res_pc;
`endif
                end else if (accept) begin
                    state_d = ST_TWO;
                    data1_d = res;
                    zero1_d = res_zero;
`ifdef LOGIC_GATE_UNIT_POPCNT_EN
                    pc1_d   = res_pc;
`endif
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    state_d = ST_ONE;
                    data0_d = data1_q;
                    zero0_d = zero1_q;
`ifdef LOGIC_GATE_UNIT_POPCNT_EN
                    pc0_d   = pc1_q;
`endif
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            data0_q    <= '0;
            data1_q    <= '0;
            zero0_q    <= 1'b0;
            zero1_q    <= 1'b0;
`ifdef LOGIC_GATE_UNIT_POPCNT_EN
            pc0_q      <= '0;
            pc1_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            zero0_q    <= zero0_d;
            zero1_q    <= zero1_d;
`ifdef LOGIC_GATE_UNIT_POPCNT_EN
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
`endif
        end
    end

endmodule
